addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shares one combinational SIZE-bit ripple-carry adder/subtractor between two requesters. Each requester presents operands and an add/sub select over a valid/ready handshake. The block arbitrates round-robin, drives the shared datapath from registered operands and waits one cycle for the carry chain to settle. It then returns a registered result with carry, signed overflow and requester ID over a valid/ready handshake. It sits between client logic and the adder/subtractor instance, which stays purely combinational.

## Interface
- SIZE, 4, operand/result width; must be ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  SIZE  requester 0 operands
- req0_sub  in  1  requester 0 select: 1 = a−b, 0 = a+b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1
- dp_a, dp_b  out  SIZE  operands to shared datapath (registered)
- dp_ctrl  out  1  datapath add/sub control (registered, 1 = subtract)
- dp_sum  in  SIZE  datapath sum
- dp_cout  in  SIZE  datapath per-bit carry vector; bit SIZE−1 is carry-out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  SIZE  registered result
- res_cout  out  1  dp_cout[SIZE−1] captured (for subtract, 1 = no borrow)
- res_ovf  out  1  signed overflow: dp_cout[SIZE−1] ^ dp_cout[SIZE−2]
- res_id  out  1  requester that issued the result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states are IDLE, EXEC and DONE. The reset state is IDLE.
- **IDLE**
  - Grant goes to a requester with valid asserted.
  - If both are valid, grant goes to the requester named by priority pointer `prio`.
  - reqN_ready = (state==IDLE) & grant==N. This is combinational and at most one ready is high.
  - On a handshake, capture a, b, sub into dp_a, dp_b, dp_ctrl and the requester index into id_q. Then go to EXEC.
  - Set prio to the other requester.
- **EXEC**
  - dp_* are held.
  - At the clock edge, capture dp_sum, dp_cout[SIZE−1] and overflow into res_* and id_q into res_id. Set res_valid=1 and go to DONE.
- **DONE**
  - res_* and dp_* are held stable.
  - When res_valid & res_ready at the edge, clear res_valid and go to IDLE.
  - No request is accepted in DONE.
- Requesters keep valid and operands stable until ready. A valid that drops without a handshake is ignored and has no side effects. prio changes only on a handshake.
- Arithmetic is modulo 2^SIZE, and the datapath does two's-complement subtraction (b inverted, carry-in = ctrl). res_ovf is meaningful for signed interpretation only.
- **Reset** (asynchronous, any state, including mid-operation)
  - state=IDLE and prio=0.
  - dp_a=dp_b=0, dp_ctrl=0.
  - res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0.
  - busy=0, both ready=0 while rst_n low.
  - An in-flight operation is discarded and never reported.

## Timing
- The accept handshake happens at edge T.
- dp_* are valid after T. EXEC is the cycle T→T+1.
- res_valid rises after edge T+1 (2-edge latency from accept).
- If res_ready is held high, the result is consumed at T+2. IDLE runs T+2→T+3 and the next accept is at edge T+3.
- Peak throughput is one operation per 3 cycles.
- With both requesters continuously valid, grants strictly alternate 0,1,0,1…, starting from 0 after reset.
- Backpressure: res_ready low holds the FSM in DONE indefinitely, with outputs unchanged.
- The combinational path dp_* → datapath → dp_sum/dp_cout must close in one clock period.
- Worst-case input-to-output settle time grows linearly with SIZE (ripple).

## Test plan
- **Reset**
  - Stimulus: assert rst_n=0 mid-EXEC.
  - Expected: all outputs 0 immediately, with no clock needed. After release, the FSM is IDLE and the next simultaneous request is granted to requester 0.
- **Single add** (SIZE=4)
  - Stimulus: req0 a=7, b=1, sub=0, res_ready=1.
  - Expected: req0_ready at T, then res_sum=8, res_cout=0, res_ovf=1, res_id=0, with res_valid high for exactly one cycle, T+1→T+2.
- **Subtracts** (SIZE=4)
  - Stimulus: req1 a=5, b=3, sub=1.
  - Expected: res_sum=2, res_cout=1, res_ovf=0, res_id=1.
  - Stimulus: then a=3, b=5, sub=1.
  - Expected: res_sum=14, res_cout=0, res_ovf=0.
- **Contention**
  - Stimulus: both requesters valid continuously for 6 operations with distinct operands.
  - Expected: res_id sequence 0,1,0,1,0,1, each result matching its issuer's operands, and the accept edges spaced 3 cycles apart.
- **Backpressure**
  - Stimulus: hold res_ready=0 for 5 cycles after res_valid rises.
  - Expected: res_* and dp_* are stable, no reqN_ready is asserted and busy=1. Releasing res_ready completes the handshake in that cycle and returns the FSM to IDLE.
- **Withdrawn request**
  - Stimulus: req1_valid pulses for one cycle while the FSM is in DONE.
  - Expected: no grant to requester 1, prio unchanged, and the next idle grant follows prio.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - requester, datapath and result signals of the add/sub arbiter
interface addsub_arbiter_if #(
  parameter int SIZE = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [SIZE-1:0] req0_a;
  logic [SIZE-1:0] req0_b;
  logic            req0_sub;
  logic            req1_valid;
  logic            req1_ready;
  logic [SIZE-1:0] req1_a;
  logic [SIZE-1:0] req1_b;
  logic            req1_sub;
  logic [SIZE-1:0] dp_a;
  logic [SIZE-1:0] dp_b;
  logic            dp_ctrl;
  logic [SIZE-1:0] dp_sum;
  logic [SIZE-1:0] dp_cout;
  logic            res_valid;
  logic            res_ready;
  logic [SIZE-1:0] res_sum;
  logic            res_cout;
  logic            res_ovf;
  logic            res_id;
  logic            busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output dp_a, dp_b, dp_ctrl,
    input  dp_sum, dp_cout,
    output res_valid, res_sum, res_cout, res_ovf, res_id,
    input  res_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  dp_a, dp_b, dp_ctrl,
    output dp_sum, dp_cout,
    input  res_valid, res_sum, res_cout, res_ovf, res_id,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sharing of one combinational add/sub datapath between two requesters
module addsub_arbiter #(
  parameter int SIZE = 4
) (
  input logic             clk,
  input logic             rst_n,
  addsub_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic            id_q, id_d;
  logic [SIZE-1:0] dp_a_q, dp_a_d;
  logic [SIZE-1:0] dp_b_q, dp_b_d;
  logic            dp_ctrl_q, dp_ctrl_d;
  logic            res_valid_q, res_valid_d;
  logic [SIZE-1:0] res_sum_q, res_sum_d;
  logic            res_cout_q, res_cout_d;
  logic            res_ovf_q, res_ovf_d;
  logic            res_id_q, res_id_d;
  logic            grant;
  logic            take;
  logic            unused_cout;

  // Ready is gated by rst_n so both readies read low while reset is held.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = prio_q;
    end
  end

  assign take           = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = take && !grant;
  assign bus.req1_ready = take && grant;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_ctrl_d   = dp_ctrl_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          dp_a_d    = grant ? bus.req1_a   : bus.req0_a;
          dp_b_d    = grant ? bus.req1_b   : bus.req0_b;
          dp_ctrl_d = grant ? bus.req1_sub : bus.req0_sub;
          id_d      = grant;
          prio_d    = !grant;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // The carry chain has had a full cycle to settle from the registered operands.
        res_sum_d   = bus.dp_sum;
        res_cout_d  = bus.dp_cout[SIZE-1];
        res_ovf_d   = bus.dp_cout[SIZE-1] ^ bus.dp_cout[SIZE-2];
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_ctrl_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_ctrl_q   <= dp_ctrl_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.dp_ctrl   = dp_ctrl_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q != IDLE);
  assign unused_cout   = ^bus.dp_cout;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench for addsub_arbiter with a ripple add/sub datapath model
module tb_addsub_arbiter;
  localparam int SIZE = 4;

  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    bit         sub;
    logic [3:0] sum;
    bit         cout;
    bit         ovf;
  } vec_t;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   res_count = 0;
  int   rv_cnt = 0;
  int   res_last_cyc = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   acc_cyc[$];
  int   acc_id[$];
  int   res_ids[$];
  vec_t vecs[8];

  addsub_arbiter_if #(.SIZE(SIZE)) bus ();

  addsub_arbiter #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit-level ripple adder standing in for the shared datapath.
  always_comb begin
    logic       c;
    logic [3:0] bb;
    bus.dp_sum  = '0;
    bus.dp_cout = '0;
    c  = bus.dp_ctrl;
    bb = bus.dp_ctrl ? ~bus.dp_b : bus.dp_b;
    for (int i = 0; i < SIZE; i++) begin
      bus.dp_sum[i]  = bus.dp_a[i] ^ bb[i] ^ c;
      c              = (bus.dp_a[i] & bb[i]) | (bus.dp_a[i] & c) | (bb[i] & c);
      bus.dp_cout[i] = c;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic sub);
    exp_t e;
    int   sa, sb, r;
    sa = int'(a);
    sb = int'(b);
    if (sa > 7) sa -= 16;
    if (sb > 7) sb -= 16;
    if (sub) begin
      e.sum  = 4'(a - b);
      e.cout = (a >= b);
      r      = sa - sb;
    end else begin
      e.sum  = 4'(a + b);
      e.cout = ((int'(a) + int'(b)) > 15);
      r      = sa + sb;
    end
    e.ovf = (r < -8) || (r > 7);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("ready_onehot", int'(bus.req0_ready & bus.req1_ready), 0);
      if (bus.req0_valid && bus.req0_ready) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(1);
      end
      if (bus.res_valid) rv_cnt++;
      if (bus.res_valid && bus.res_ready) begin
        if (bus.res_id == 1'b0 && exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
        end else if (bus.res_id == 1'b1 && exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
        end else begin
          check("sb_unexpected_result", 1, 0);
          e = '{bus.res_sum, bus.res_cout, bus.res_ovf};
        end
        check("res_sum", bus.res_sum, e.sum);
        check("res_cout", bus.res_cout, e.cout);
        check("res_ovf", bus.res_ovf, e.ovf);
        res_ids.push_back(int'(bus.res_id));
        res_last_cyc = cyc;
        res_count++;
      end
    end
  end

  task automatic drive_op(input bit id, input logic [3:0] a, input logic [3:0] b, input logic s);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = a;
      bus.req0_b     = b;
      bus.req0_sub   = s;
    end else begin
      bus.req1_valid = 1'b1;
      bus.req1_a     = a;
      bus.req1_b     = b;
      bus.req1_sub   = s;
    end
  endtask

  task automatic present(input bit id);
    logic [3:0] a, b;
    logic       s;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    s = 1'($urandom_range(0, 1));
    drive_op(id, a, b, s);
    if (id == 1'b0) exp_q0.push_back(model(a, b, s));
    else            exp_q1.push_back(model(a, b, s));
  endtask

  task automatic run_vec(input vec_t v);
    int na  = acc_id.size();
    int nr  = res_count;
    int rv0 = rv_cnt;
    drive_op(v.id, v.a, v.b, v.sub);
    if (v.id == 1'b0) exp_q0.push_back('{v.sum, v.cout, v.ovf});
    else              exp_q1.push_back('{v.sum, v.cout, v.ovf});
    for (int g = 0; g < 20; g++) begin
      @(posedge clk);
      if (acc_id.size() > na) break;
    end
    check("vec_accepted", int'(acc_id.size() > na), 1);
    #1;
    if (v.id == 1'b0) bus.req0_valid = 1'b0;
    else              bus.req1_valid = 1'b0;
    if (acc_id.size() > na) check("vec_accept_id", acc_id[na], int'(v.id));
    for (int g = 0; g < 20; g++) begin
      @(posedge clk);
      if (res_count > nr) break;
    end
    check("vec_result_seen", int'(res_count > nr), 1);
    #1;
    @(posedge clk);
    #1;
    if (acc_cyc.size() > na) check("vec_latency", res_last_cyc - acc_cyc[na], 2);
    check("vec_valid_cycles", rv_cnt - rv0, 1);
  endtask

  task automatic run_both(input int n, input int first);
    int base  = acc_id.size();
    int rbase = res_ids.size();
    int i0 = 1, i1 = 1, got = 0;
    present(1'b0);
    present(1'b1);
    for (int g = 0; g < n * 6 + 10 && got < n; g++) begin
      @(posedge clk);
      if (acc_id.size() > base + got) begin
        int id = acc_id[base + got];
        got++;
        #1;
        if (id == 0) begin
          if (i0 < n / 2) begin present(1'b0); i0++; end
          else bus.req0_valid = 1'b0;
        end else begin
          if (i1 < n / 2) begin present(1'b1); i1++; end
          else bus.req1_valid = 1'b0;
        end
      end
    end
    check("both_accept_count", got, n);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(posedge clk);
      if (res_ids.size() >= rbase + n) break;
    end
    #1;
    for (int k = 0; k < n; k++) begin
      if (res_ids.size() > rbase + k) check("res_id_order", res_ids[rbase + k], first ^ (k & 1));
      else check("res_missing", 0, 1);
    end
    for (int k = 1; k < got; k++) begin
      check("accept_id_order", acc_id[base + k], first ^ (k & 1));
      check("accept_spacing", acc_cyc[base + k] - acc_cyc[base + k - 1], 3);
    end
  endtask

  initial begin
    int na, nr, rv0;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_sub   = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_sub   = 1'b0;
    bus.res_ready  = 1'b1;

    vecs[0] = '{1'b0, 4'd7, 4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'd5, 4'd3, 1'b1, 4'd2,  1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'd8, 4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    vecs[4] = '{1'b1, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd4, 4'd4, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd0,  1'b1, 1'b0};
    vecs[7] = '{1'b1, 4'd9, 4'd9, 1'b0, 4'd2,  1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_dp_a", bus.dp_a, 0);
    check("rst_res_sum", bus.res_sum, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of EXEC discards the operation.
    na = acc_id.size();
    drive_op(1'b0, 4'd9, 4'd6, 1'b0);
    for (int g = 0; g < 20; g++) begin
      @(posedge clk);
      if (acc_id.size() > na) break;
    end
    #1;
    bus.req1_valid = 1'b1;
    check("exec_dp_a", bus.dp_a, 9);
    check("exec_dp_b", bus.dp_b, 6);
    check("exec_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dp_a", bus.dp_a, 0);
    check("arst_dp_b", bus.dp_b, 0);
    check("arst_dp_ctrl", bus.dp_ctrl, 0);
    check("arst_res_valid", bus.res_valid, 0);
    check("arst_res_sum", bus.res_sum, 0);
    check("arst_res_cout", bus.res_cout, 0);
    check("arst_res_ovf", bus.res_ovf, 0);
    check("arst_res_id", bus.res_id, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_req0_ready", bus.req0_ready, 0);
    check("arst_req1_ready", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv0 = rv_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("arst_no_stale_result", rv_cnt - rv0, 0);
    check("arst_idle_busy", bus.busy, 0);

    run_both(6, 0);

    // Backpressure with a one-cycle request pulse while held in DONE.
    bus.res_ready = 1'b0;
    na = acc_id.size();
    nr = res_count;
    drive_op(1'b0, 4'd6, 4'd11, 1'b1);
    exp_q0.push_back('{4'd11, 1'b0, 1'b1});
    for (int g = 0; g < 20; g++) begin
      @(posedge clk);
      if (acc_id.size() > na) break;
    end
    #1;
    bus.req0_valid = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) break;
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        drive_op(1'b0, 4'd1, 4'd2, 1'b0);
        drive_op(1'b1, 4'd3, 4'd4, 1'b0);
      end else begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_sum", bus.res_sum, 11);
      check("bp_res_cout", bus.res_cout, 0);
      check("bp_res_ovf", bus.res_ovf, 1);
      check("bp_res_id", bus.res_id, 0);
      check("bp_dp_a", bus.dp_a, 6);
      check("bp_dp_b", bus.dp_b, 11);
      check("bp_dp_ctrl", bus.dp_ctrl, 1);
      check("bp_busy", bus.busy, 1);
      check("bp_req0_ready", bus.req0_ready, 0);
      check("bp_req1_ready", bus.req1_ready, 0);
      @(posedge clk);
      #1;
    end
    check("bp_not_consumed", res_count - nr, 0);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_consumed", res_count - nr, 1);
    check("bp_release_idle", bus.busy, 0);
    check("bp_release_valid", bus.res_valid, 0);

    run_both(2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
